// File: rtl/para_decoder.sv
// Binary-to-one-hot decoder with enable, range error flag and registered outputs.
// Optional PARA_DECODER_HOLD_EN: when enable is low, out/out_valid hold instead of clearing.
module para_decoder #(
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  in,
   input  logic                 enable,
   output logic [OUT_WIDTH-1:0] out,
   output logic                 out_valid,
   output logic                 range_err
);

   if (IN_WIDTH < 1 || IN_WIDTH > 16) begin : g_bad_in_width
      $error("para_decoder: IN_WIDTH=%0d outside 1..16", IN_WIDTH);
   end
   if (OUT_WIDTH < 1 || OUT_WIDTH > (1 << IN_WIDTH)) begin : g_bad_out_width
      $error("para_decoder: OUT_WIDTH=%0d outside 1..2**IN_WIDTH", OUT_WIDTH);
   end

   logic [OUT_WIDTH-1:0] dec;
   logic                 in_range;
   logic [OUT_WIDTH-1:0] out_d;
   logic                 valid_d;
   logic                 err_d;

   // Full-width unsigned compare; in is zero-extended so no index bits are dropped.
   assign in_range = (32'(in) < 32'(OUT_WIDTH));

   // Each line compares against its own index, so at most one line can match.
   always_comb begin
      dec = '0;
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
         dec[i] = in_range && (32'(in) == i);
      end
   end

   always_comb begin
      out_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (enable) begin
         if (in_range) begin
            out_d   = dec;
            valid_d = 1'b1;
         end else begin
            err_d   = 1'b1;
         end
      end else begin
`ifdef PARA_DECODER_HOLD_EN
         out_d   = out;
         valid_d = out_valid;
`else
         out_d   = '0;
         valid_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         range_err <= 1'b0;
      end else begin
         out       <= out_d;
         out_valid <= valid_d;
         range_err <= err_d;
      end
   end

endmodule

// File: tb/tb_para_decoder.sv
// Self-checking bench for para_decoder: a 2/4 instance and a 3/5 instance driven side by side,
// checked with constant tables, hand-written sequences and a randomized reference model.
module tb_para_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_a, en_b;
   logic [1:0] in_a;
   logic [2:0] in_b;
   logic [3:0] out_a;
   logic [4:0] out_b;
   logic       val_a, val_b, err_a, err_b;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   int ma_o, mb_o;
   bit ma_v, ma_e, mb_v, mb_e;

`ifdef PARA_DECODER_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   typedef struct {
      logic       en;
      logic [2:0] in;
      logic [4:0] out;
      logic       val;
      logic       err;
   } vec_t;

   vec_t tab_a[5];
   vec_t tab_b[6];

   always #5 clk = ~clk;

   para_decoder #(.IN_WIDTH(2), .OUT_WIDTH(4)) dut_a (
      .clk(clk), .rst(rst), .in(in_a), .enable(en_a),
      .out(out_a), .out_valid(val_a), .range_err(err_a)
   );

   para_decoder #(.IN_WIDTH(3), .OUT_WIDTH(5)) dut_b (
      .clk(clk), .rst(rst), .in(in_b), .enable(en_b),
      .out(out_b), .out_valid(val_b), .range_err(err_b)
   );

   function automatic void ref_step(input int ow, input bit en, input int idx,
                                    input int po, input bit pv,
                                    output int o, output bit v, output bit e);
      if (en && idx < ow) begin
         o = 1 << idx; v = 1'b1; e = 1'b0;
      end else if (en) begin
         o = 0; v = 1'b0; e = 1'b1;
      end else begin
         o = HOLD ? po : 0;
         v = HOLD ? pv : 1'b0;
         e = 1'b0;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " out_a"}, 32'(out_a), ma_o);
      check({tag, " val_a"}, 32'(val_a), 32'(ma_v));
      check({tag, " err_a"}, 32'(err_a), 32'(ma_e));
      check({tag, " out_b"}, 32'(out_b), mb_o);
      check({tag, " val_b"}, 32'(val_b), 32'(mb_v));
      check({tag, " err_b"}, 32'(err_b), 32'(mb_e));
      check({tag, " onehot_a"}, 32'($countones(out_a) <= 1), 32'd1);
      check({tag, " onehot_b"}, 32'($countones(out_b) <= 1), 32'd1);
   endtask

   task automatic reset_model();
      ma_o = 0; ma_v = 0; ma_e = 0;
      mb_o = 0; mb_v = 0; mb_e = 0;
   endtask

   // Drive both instances, take one rising edge, advance the model with the sampled inputs.
   task automatic step(input logic ea, input logic [1:0] ia, input logic eb, input logic [2:0] ib);
      int o; bit v, e;
      en_a = ea; in_a = ia; en_b = eb; in_b = ib;
      @(posedge clk);
      #1;
      ref_step(4, ea, int'(ia), ma_o, ma_v, o, v, e); ma_o = o; ma_v = v; ma_e = e;
      ref_step(5, eb, int'(ib), mb_o, mb_v, o, v, e); mb_o = o; mb_v = v; mb_e = e;
   endtask

   initial begin
      tab_a[0] = '{1'b1, 3'd0, 5'b00001, 1'b1, 1'b0};
      tab_a[1] = '{1'b1, 3'd1, 5'b00010, 1'b1, 1'b0};
      tab_a[2] = '{1'b1, 3'd2, 5'b00100, 1'b1, 1'b0};
      tab_a[3] = '{1'b1, 3'd3, 5'b01000, 1'b1, 1'b0};
      tab_a[4] = '{1'b0, 3'd1, HOLD ? 5'b01000 : 5'b00000, HOLD, 1'b0};
      tab_b[0] = '{1'b1, 3'd5, 5'b00000, 1'b0, 1'b1};
      tab_b[1] = '{1'b1, 3'd6, 5'b00000, 1'b0, 1'b1};
      tab_b[2] = '{1'b1, 3'd7, 5'b00000, 1'b0, 1'b1};
      tab_b[3] = '{1'b1, 3'd4, 5'b10000, 1'b1, 1'b0};
      tab_b[4] = '{1'b1, 3'd2, 5'b00100, 1'b1, 1'b0};
      tab_b[5] = '{1'b0, 3'd3, HOLD ? 5'b00100 : 5'b00000, HOLD, 1'b0};

      rst = 1'b1; en_a = 1'b1; in_a = 2'd2; en_b = 1'b1; in_b = 3'd2;
      reset_model();
      #1;
      check_all("reset_initial");
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-cycle with a live decode on the outputs.
      step(1'b1, 2'd2, 1'b1, 3'd2);
      check_all("pre_async_reset");
      #2 rst = 1'b1;
      #1;
      reset_model();
      check_all("async_reset");
      @(negedge clk);
      rst = 1'b0;

      foreach (tab_a[i]) begin
         step(tab_a[i].en, tab_a[i].in[1:0], 1'b0, 3'd0);
         check($sformatf("tab_a[%0d] out", i), 32'(out_a), 32'(tab_a[i].out));
         check($sformatf("tab_a[%0d] val", i), 32'(val_a), 32'(tab_a[i].val));
         check($sformatf("tab_a[%0d] err", i), 32'(err_a), 32'(tab_a[i].err));
      end

      foreach (tab_b[i]) begin
         step(1'b0, 2'd0, tab_b[i].en, tab_b[i].in);
         check($sformatf("tab_b[%0d] out", i), 32'(out_b), 32'(tab_b[i].out));
         check($sformatf("tab_b[%0d] val", i), 32'(val_b), 32'(tab_b[i].val));
         check($sformatf("tab_b[%0d] err", i), 32'(err_b), 32'(tab_b[i].err));
      end

      // Latency: an input change between edges must not reach the outputs.
      step(1'b1, 2'd1, 1'b1, 3'd1);
      check_all("latency_before");
      #2;
      en_a = 1'b1; in_a = 2'd3; en_b = 1'b1; in_b = 3'd6;
      #1;
      check_all("latency_midcycle");
      step(1'b1, 2'd3, 1'b1, 3'd6);
      check_all("latency_after");

      for (int k = 0; k < 60; k++) begin
         step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom));
         check_all($sformatf("rand[%0d]", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/para_decoder.md
Name: para_decoder

Overview:
Parameterized binary-to-one-hot decoder with enable and a registered output. An IN_WIDTH-bit index selects one of OUT_WIDTH output lines. Used for select/chip-enable generation in address-decode and mux-control paths. One clock domain; asynchronous active-high reset.

Parameters:
IN_WIDTH, 2, width of binary index input; legal range 1..16.
OUT_WIDTH, 4, number of one-hot output lines; legal range 1..2**IN_WIDTH. Elaboration-time error if out of range.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; asynchronous assert, active-high.
in  input  IN_WIDTH  binary index to decode; unsigned.
enable  input  1  decode enable; active-high.
out  output  OUT_WIDTH  registered one-hot decode result.
out_valid  output  1  registered; 1 when out holds a decode of an enabled, in-range index.
range_err  output  1  registered; 1 when enable was 1 and in >= OUT_WIDTH.

Behaviour:
- Reset: rst high forces out = 0, out_valid = 0, range_err = 0 immediately, with no clock needed; held while rst = 1. First decode is captured at the first rising clk edge after rst deasserts.
- Latency: 1 cycle. Inputs sampled at a rising clk edge appear on the outputs after that edge.
- Decode at each rising edge with rst = 0:
  - enable = 1 and in < OUT_WIDTH: out = 1 << in (exactly one bit set, bit index = in); out_valid = 1; range_err = 0.
  - enable = 1 and in >= OUT_WIDTH: out = 0; out_valid = 0; range_err = 1. Only possible when OUT_WIDTH < 2**IN_WIDTH.
  - enable = 0: out = 0 (default build); out_valid = 0; range_err = 0. The in value is ignored.
- Invariant: out is always all-zero or one-hot, never multi-hot.
- The index compare is unsigned and done at full IN_WIDTH, with no truncation of in.
- X/Z on in while enable = 1: implementation-defined, but out must never be multi-hot.
- Reset mid-operation: outputs clear asynchronously. In-flight sampled data is discarded.
- No internal state other than the output registers.

Optional Feature:
Macro PARA_DECODER_HOLD_EN.
- Defined: when enable = 0 at a clock edge, out and out_valid hold their previous values, and range_err clears to 0. Reset still clears everything.
- Not defined: enable = 0 drives out = 0 and out_valid = 0 at the next edge, as specified above.
- Enabled decode and range-error behaviour are identical in both builds.

Test Plan:
- Reset: assert rst = 1 asynchronously mid-cycle with enable = 1, in = 2 -> out = 4'b0000, out_valid = 0, range_err = 0 immediately, with no clock edge.
- Exhaustive enabled decode (IN_WIDTH = 2, OUT_WIDTH = 4): enable = 1, in = 0,1,2,3 on consecutive edges -> one cycle later out = 0001, 0010, 0100, 1000; out_valid = 1 each cycle.
- Disable: enable = 1, in = 3, then enable = 0, in = 1 -> out = 1000, then 0000 with out_valid = 0. With PARA_DECODER_HOLD_EN: out stays 1000, out_valid stays 1.
- Out of range (IN_WIDTH = 3, OUT_WIDTH = 5): enable = 1, in = 5, 6, 7 -> out = 00000, range_err = 1, out_valid = 0. Then in = 4 -> out = 10000, range_err = 0.
- Random: 10+ cycles of random {enable, in} -> out equals the registered reference model one cycle later; $countones(out) <= 1 always.
- Latency: change in between clock edges -> out is unchanged until the next rising clk edge.
